speed_arbiter_ctrl: RTL and testbench
=====================================

SPEED_ARBITER_CTRL -- requirements
Module: speed_arbiter_ctrl

Interface
REQ-001 SHALL have parameter MAX_SPEED, default 120, upper speed limit (must be ≤255).
REQ-002 SHALL have parameter ACCEL_STEP, default 2, speed increment per ACCEL cycle.
REQ-003 SHALL have parameter BRAKE_STEP, default 4, speed decrement per BRAKE cycle.
REQ-004 SHALL have parameter HOLD, default 2, consecutive high samples needed to qualify a request (≥1).
REQ-005 SHALL have parameter COAST_DIV, default 8, IDLE cycles per 1-unit coast decrement (≥1).
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port clr_bar  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port accel_req  input  1  accelerate request from the driver pedal.
REQ-009 SHALL have port brake_req  input  1  brake request.
REQ-010 SHALL have port cruise_en  input  1  hold speed when no request is qualified.
REQ-011 SHALL have port speed  output  8  current speed, registered.
REQ-012 SHALL have port accel_gnt  output  1  high while state is ACCEL.
REQ-013 SHALL have port brake_gnt  output  1  high while state is BRAKE.
REQ-014 SHALL have port at_max  output  1  speed == MAX_SPEED.
REQ-015 SHALL have port at_min  output  1  speed == 0.
REQ-016 SHALL have port state  output  2  encoded FSM state.

Function
REQ-017 SHALL qualify each request separately: per-request saturating counter increments on each edge where the request is high, clears on an edge where it is low; qualified = (count == HOLD), registered.
REQ-018 SHALL implement a Moore FSM with states IDLE=0, ACCEL=1, BRAKE=2, CRUISE=3; all outputs depend on registers only.
REQ-019 SHALL compute next state from qualified signals only: brake_q → BRAKE; else accel_q → ACCEL; else cruise_en → CRUISE; else IDLE. Any state may go to any state in one edge.
REQ-020 SHALL give brake strict priority: both qualified → BRAKE, accel_gnt low.
REQ-021 SHALL update speed on each edge according to the current state: ACCEL → min(speed+ACCEL_STEP, MAX_SPEED); BRAKE → max(speed−BRAKE_STEP, 0); CRUISE → hold.
REQ-022 SHALL do the saturating arithmetic in 9 bits so that no wrap-around can occur at 255 or below 0.
REQ-023 SHALL, in IDLE, count coast cycles 0..COAST_DIV−1; on the edge where count==COAST_DIV−1, decrement speed by 1 (floor 0) and wrap the count to 0.
REQ-024 SHALL clear the coast counter in any state other than IDLE.
REQ-025 SHALL give a latency of HOLD+2 edges from the first sampled request edge to the first speed change; gnt rises HOLD+1 edges after the first sampled request edge.
REQ-026 SHALL deassert the grant 2 edges after the request is first sampled low (qualifier clears, then state leaves).
REQ-027 SHALL keep the grant asserted and hold speed at the limit when accelerating at MAX_SPEED or braking at 0.

Reset
REQ-028 SHALL, on clr_bar low, asynchronously set: state=IDLE, speed=0, qualifier counts=0, coast count=0, accel_gnt=0, brake_gnt=0, at_max=0, at_min=1.
REQ-029 SHALL let reset asserted mid-ACCEL/BRAKE abort immediately; after release, requests must requalify from count 0.

Structure
REQ-030 SHALL place the state encoding constants (IDLE, ACCEL, BRAKE, CRUISE) and the 8-bit speed width constant in the shared speed-control package.
REQ-031 SHALL instantiate sub-module req_qualifier (clk, clr_bar, req, qual; parameter HOLD) twice, once per request.

Verification
REQ-032 SHALL cover this case: accel_req high from edge 1, defaults → accel_gnt high after edge 3, speed=2 after edge 4, then +2 per edge, saturating at 120 with at_max=1.
REQ-033 SHALL cover this case: accel_req high for 1 cycle only (glitch) → no grant, speed unchanged.
REQ-034 SHALL cover this case: speed=60, ACCEL, brake_req asserted → BRAKE 3 edges later, accel_gnt low, speed falls 4 per edge to 0, at_min=1, brake_gnt stays high.
REQ-035 SHALL cover this case: speed=10, no requests, cruise_en=0 → speed=9 after 8 IDLE edges, 0 after 80 edges. cruise_en=1 → speed held at 10.
REQ-036 SHALL cover this case: both requests high together → only brake_gnt ever asserts.
REQ-037 SHALL cover this case: clr_bar pulsed low mid-ACCEL at speed=40 → speed=0, state=IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/speed_arbiter_ctrl_pkg.sv
// Shared speed-control definitions.
//   SPEED_W : width of the speed datapath (8 bits).
//   state_t : FSM state encoding (IDLE=0, ACCEL=1, BRAKE=2, CRUISE=3).
package speed_arbiter_ctrl_pkg;

  localparam int unsigned SPEED_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    BRAKE  = 2'd2,
    CRUISE = 2'd3
  } state_t;

endpackage

// File: rtl/speed_arbiter_ctrl_req_qualifier.sv
// Request qualifier: a saturating counter of consecutive high samples.
// The counter clears on any low sample; qual is registered and goes high
// on the same edge that the counter reaches HOLD.
//   clk     : clock, rising edge
//   clr_bar : asynchronous active-low reset
//   req     : raw request
//   qual    : request held high for HOLD consecutive edges
module req_qualifier #(
  parameter int unsigned HOLD = 2
) (
  input  logic clk,
  input  logic clr_bar,
  input  logic req,
  output logic qual
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (req) cnt_nxt = (cnt == HOLD_C) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      cnt  <= '0;
      qual <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      qual <= (cnt_nxt == HOLD_C);
    end
  end

endmodule

// File: rtl/speed_arbiter_ctrl.sv
// Speed arbiter: qualifies accelerate/brake requests and drives a Moore FSM
// that ramps, brakes, holds or coasts an 8-bit speed value.
//   clk       : clock, rising edge
//   clr_bar   : asynchronous active-low reset
//   accel_req : accelerate request
//   brake_req : brake request (priority over accelerate)
//   cruise_en : hold speed when nothing is qualified
//   speed     : current speed (registered)
//   accel_gnt : state is ACCEL
//   brake_gnt : state is BRAKE
//   at_max    : speed == MAX_SPEED
//   at_min    : speed == 0
//   state     : encoded FSM state
module speed_arbiter_ctrl
  import speed_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned MAX_SPEED  = 120,
  parameter int unsigned ACCEL_STEP = 2,
  parameter int unsigned BRAKE_STEP = 4,
  parameter int unsigned HOLD       = 2,
  parameter int unsigned COAST_DIV  = 8
) (
  input  logic               clk,
  input  logic               clr_bar,
  input  logic               accel_req,
  input  logic               brake_req,
  input  logic               cruise_en,
  output logic [SPEED_W-1:0] speed,
  output logic               accel_gnt,
  output logic               brake_gnt,
  output logic               at_max,
  output logic               at_min,
  output logic [1:0]         state
);

  localparam int unsigned CDW = (COAST_DIV > 1) ? $clog2(COAST_DIV) : 1;
  localparam logic [CDW-1:0]   COAST_LAST = CDW'(COAST_DIV - 1);
  localparam logic [SPEED_W:0] MAX9 = (SPEED_W + 1)'(MAX_SPEED);
  localparam logic [SPEED_W:0] ACC9 = (SPEED_W + 1)'(ACCEL_STEP);
  localparam logic [SPEED_W:0] BRK9 = (SPEED_W + 1)'(BRAKE_STEP);

  logic accel_q;
  logic brake_q;

  req_qualifier #(.HOLD(HOLD)) u_accel_qual (
    .clk     (clk),
    .clr_bar (clr_bar),
    .req     (accel_req),
    .qual    (accel_q)
  );

  req_qualifier #(.HOLD(HOLD)) u_brake_qual (
    .clk     (clk),
    .clr_bar (clr_bar),
    .req     (brake_req),
    .qual    (brake_q)
  );

  state_t             st;
  state_t             st_nxt;
  logic [CDW-1:0]     coast_cnt;
  logic [CDW-1:0]     coast_nxt;
  logic [SPEED_W-1:0] speed_nxt;
  logic [SPEED_W:0]   up9;
  logic [SPEED_W-1:0] dn;
  logic               coast_wrap;

  always_comb begin
    st_nxt = IDLE;
    if (brake_q)        st_nxt = BRAKE;
    else if (accel_q)   st_nxt = ACCEL;
    else if (cruise_en) st_nxt = CRUISE;

    // Nine-bit sum so the clamp sees the true value even past 255.
    up9 = {1'b0, speed} + ACC9;
    if (up9 > MAX9) up9 = MAX9;
    dn = ({1'b0, speed} < BRK9) ? '0 : speed - BRK9[SPEED_W-1:0];

    coast_wrap = (coast_cnt == COAST_LAST);
    coast_nxt  = '0;
    speed_nxt  = speed;
    unique case (st)
      ACCEL:  speed_nxt = up9[SPEED_W-1:0];
      BRAKE:  speed_nxt = dn;
      CRUISE: speed_nxt = speed;
      IDLE: begin
        coast_nxt = coast_wrap ? '0 : coast_cnt + 1'b1;
        if (coast_wrap && speed != '0) speed_nxt = speed - 1'b1;
      end
      default: speed_nxt = speed;
    endcase
  end

  // Flags are registered from next-state values so they line up with the
  // registered state/speed they describe.
  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      st        <= IDLE;
      speed     <= '0;
      coast_cnt <= '0;
      accel_gnt <= 1'b0;
      brake_gnt <= 1'b0;
      at_max    <= 1'b0;
      at_min    <= 1'b1;
    end else begin
      st        <= st_nxt;
      speed     <= speed_nxt;
      coast_cnt <= coast_nxt;
      accel_gnt <= (st_nxt == ACCEL);
      brake_gnt <= (st_nxt == BRAKE);
      at_max    <= (speed_nxt == MAX9[SPEED_W-1:0]);
      at_min    <= (speed_nxt == '0);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_speed_arbiter_ctrl.sv
// Directed bench for speed_arbiter_ctrl with default parameters.
module tb_speed_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       clr_bar;
  logic       accel_req;
  logic       brake_req;
  logic       cruise_en;
  logic [7:0] speed;
  logic       accel_gnt;
  logic       brake_gnt;
  logic       at_max;
  logic       at_min;
  logic [1:0] state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  speed_arbiter_ctrl #(
    .MAX_SPEED  (120),
    .ACCEL_STEP (2),
    .BRAKE_STEP (4),
    .HOLD       (2),
    .COAST_DIV  (8)
  ) dut (
    .clk       (clk),
    .clr_bar   (clr_bar),
    .accel_req (accel_req),
    .brake_req (brake_req),
    .cruise_en (cruise_en),
    .speed     (speed),
    .accel_gnt (accel_gnt),
    .brake_gnt (brake_gnt),
    .at_max    (at_max),
    .at_min    (at_min),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_bar   = 1'b0;
    accel_req = 1'b0;
    brake_req = 1'b0;
    cruise_en = 1'b0;
    repeat (2) @(negedge clk);
    clr_bar = 1'b1;
  endtask

  initial begin
    // Reset values and accelerate ramp to saturation
    do_reset();
    check_val("rst_speed", speed, 0);
    check_val("rst_state", state, 0);
    check_val("rst_agnt", accel_gnt, 0);
    check_val("rst_bgnt", brake_gnt, 0);
    check_val("rst_at_max", at_max, 0);
    check_val("rst_at_min", at_min, 1);
    accel_req = 1'b1;
    tick(); check_val("acc_e1_state", state, 0);
    tick(); check_val("acc_e2_gnt", accel_gnt, 0);
    tick(); check_val("acc_e3_gnt", accel_gnt, 1);
    check_val("acc_e3_state", state, 1);
    check_val("acc_e3_speed", speed, 0);
    tick(); check_val("acc_e4_speed", speed, 2);
    check_val("acc_e4_at_min", at_min, 0);
    for (int n = 5; n <= 70; n++) begin
      tick();
      check_val("acc_ramp", speed, (n <= 63) ? 2 * (n - 3) : 120);
      if (n == 62) check_val("acc_e62_at_max", at_max, 0);
    end
    check_val("acc_sat_at_max", at_max, 1);
    check_val("acc_sat_gnt", accel_gnt, 1);

    // Asynchronous reset mid-ACCEL, then requalification
    do_reset();
    accel_req = 1'b1;
    repeat (23) tick();
    check_val("arst_pre_speed", speed, 40);
    #2 clr_bar = 1'b0;
    #1;
    check_val("arst_speed", speed, 0);
    check_val("arst_state", state, 0);
    check_val("arst_gnt", accel_gnt, 0);
    @(negedge clk);
    clr_bar = 1'b1;
    tick(); check_val("arst_req_e1", state, 0);
    tick(); check_val("arst_req_e2", state, 0);
    tick(); check_val("arst_req_e3", state, 1);

    // One-cycle glitch must not qualify
    do_reset();
    accel_req = 1'b1;
    tick();
    accel_req = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      check_val("glitch_gnt", accel_gnt, 0);
      check_val("glitch_speed", speed, 0);
    end

    // Coast down from 10 in IDLE
    do_reset();
    accel_req = 1'b1;
    repeat (6) tick();
    check_val("coast_pre6", speed, 6);
    accel_req = 1'b0;
    tick(); check_val("coast_e7_speed", speed, 8);
    check_val("coast_e7_gnt", accel_gnt, 1);
    tick(); check_val("coast_e8_speed", speed, 10);
    check_val("coast_e8_state", state, 0);
    for (int k = 1; k <= 80; k++) begin
      tick();
      check_val("coast_speed", speed, 10 - k / 8);
    end
    check_val("coast_at_min", at_min, 1);
    repeat (10) tick();
    check_val("coast_floor", speed, 0);

    // Cruise holds speed at 10
    do_reset();
    cruise_en = 1'b1;
    accel_req = 1'b1;
    tick(); check_val("cruise_e1_state", state, 3);
    repeat (5) tick();
    accel_req = 1'b0;
    repeat (2) tick();
    check_val("cruise_e8_state", state, 3);
    check_val("cruise_e8_speed", speed, 10);
    repeat (20) tick();
    check_val("cruise_hold", speed, 10);
    cruise_en = 1'b0;

    // Brake from 60 while accelerating
    do_reset();
    accel_req = 1'b1;
    repeat (33) tick();
    check_val("brk_pre_speed", speed, 60);
    brake_req = 1'b1;
    tick(); check_val("brk_e1_speed", speed, 62);
    check_val("brk_e1_state", state, 1);
    tick(); check_val("brk_e2_speed", speed, 64);
    tick(); check_val("brk_e3_state", state, 2);
    check_val("brk_e3_bgnt", brake_gnt, 1);
    check_val("brk_e3_agnt", accel_gnt, 0);
    check_val("brk_e3_speed", speed, 66);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_val("brk_ramp", speed, 66 - 4 * k);
    end
    check_val("brk_at_min_2", at_min, 0);
    tick(); check_val("brk_floor", speed, 0);
    check_val("brk_at_min", at_min, 1);
    repeat (5) tick();
    check_val("brk_hold_speed", speed, 0);
    check_val("brk_hold_gnt", brake_gnt, 1);

    // Both requests together: brake only
    do_reset();
    accel_req = 1'b1;
    brake_req = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check_val("both_agnt", accel_gnt, 0);
      check_val("both_bgnt", brake_gnt, (n >= 3) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
